btn_tick_conditioner: RTL
=========================

// Module: btn_tick_conditioner
// PURPOSE
// Front-end stage feeding DCD_Project_Top. Turns raw, asynchronous, bouncing push-button pins into
// clean one-cycle pulses: start_btn, inc_btn and dec_btn. inc/dec auto-repeat while held.
// Also divides the system clock into the one-cycle tick_1s strobe used by the clock-mode counter.
// PARAMETERS
// DEBOUNCE_CYCLES  1_000_000    stable cycles needed before a debounced level changes (10 ms @100 MHz)
// TICK_DIV         100_000_000  clk cycles per tick_1s period (must be >= 2)
// REPEAT_DELAY     50_000_000   held cycles after first inc/dec pulse before auto-repeat starts
// REPEAT_RATE      20_000_000   cycles between auto-repeat pulses (must be >= 1)
// PORTS
// clk          in   1  system clock, all logic on rising edge
// rst_n        in   1  asynchronous active-low reset
// start_raw    in   1  raw start push-button, async, active-high
// inc_raw      in   1  raw increment push-button, async, active-high
// dec_raw      in   1  raw decrement push-button, async, active-high
// tick_clr     in   1  sync clear of the 1 s prescaler (used when leaving set mode)
// start_btn    out  1  one-cycle pulse per debounced start press
// inc_btn      out  1  one-cycle pulse per inc press / auto-repeat
// dec_btn      out  1  one-cycle pulse per dec press / auto-repeat
// tick_1s      out  1  one-cycle strobe every TICK_DIV cycles
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0; synchronizers, debounced levels, counters and FSMs cleared
//   immediately. Outputs stay 0 while rst_n=0. A reset during a pulse or a count aborts it; no output is held over.
// - Sync: each raw input goes through a 2-FF synchronizer (s2 = output of the second flop).
// - Debounce, per button, with counter cnt and level db:
//   - if s2==db, cnt<=0;
//   - else if cnt==DEBOUNCE_CYCLES-1, then db<=s2 and cnt<=0;
//   - else cnt<=cnt+1.
//   - A single-cycle glitch of any length < DEBOUNCE_CYCLES never changes db.
// - Press edge: a registered pulse is issued in the cycle after db rises 0->1. Release produces no pulse.
// - Latency: for raw held high from before edge k, the pulse is high in the cycle after edge
//   k+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges. It is exactly 1 cycle wide.
// - A button held through reset release is seen as 0->1 and pulses once after the latency.
// - start: no auto-repeat; exactly one pulse per debounced press.
// - inc/dec FSM (one each), with states IDLE, WAIT, REPEAT and counter rc:
//   - IDLE: on db rise, emit pulse, then go to WAIT with rc<=0.
//   - WAIT: rc counts; when rc==REPEAT_DELAY-1, emit pulse, go to REPEAT, rc<=0.
//   - REPEAT: when rc==REPEAT_RATE-1, emit pulse and rc<=0.
//   - WAIT/REPEAT: db fall goes to IDLE at once; no pulse that cycle.
// - inc/dec interlock: while both db_inc and db_dec are 1:
//   - neither inc_btn nor dec_btn pulses;
//   - both FSMs are forced to IDLE.
//   - After one is released, the still-held button is treated as a new press: pulse, then WAIT.
//   - Two db rises in the same cycle produce no pulse.
// - inc_btn and dec_btn are never high in the same cycle. start_btn is independent.
// - Tick prescaler pc (width $clog2(TICK_DIV)):
//   - pc counts 0..TICK_DIV-1 and wraps to 0;
//   - tick_1s is registered high for the one cycle after pc==TICK_DIV-1;
//   - tick_clr=1 forces pc<=0 and tick_1s<=0 that cycle, overriding wrap.
//   - First tick after reset or after clearing: TICK_DIV edges after release.
// - Counter widths come from $clog2 of each parameter. All compares are unsigned; no counter overflows.
// TESTING (DEBOUNCE_CYCLES=4, TICK_DIV=10, REPEAT_DELAY=20, REPEAT_RATE=5)
// 1. Reset: hold rst_n=0 with all raw=1 -> all outputs 0. After release, one start_btn pulse at edge 7.
// 2. Bounce: toggle start_raw 1/0 every 2 cycles for 20 cycles -> no pulse.
//    Then hold 1 -> exactly one start_btn pulse, 7 edges after the hold starts.
// 3. Auto-repeat: hold inc_raw 60 cycles -> inc_btn pulses at edges 7, 27, 32, 37, ...
//    Release -> no further pulses.
// 4. Interlock: hold dec, then assert inc -> no pulses while both debounced.
//    Release dec -> one inc_btn pulse; dec_btn never coincides with inc_btn.
// 5. Tick: free-run 100 cycles -> tick_1s every 10 cycles, width 1.
//    Pulse tick_clr mid-period -> next tick exactly 10 edges later.
// 6. Mid-op reset: drop rst_n during REPEAT -> inc_btn=0 at once.
//    Release with inc held -> fresh single pulse after 7 edges, then delay of 20.

Source files
------------

// File: rtl/btn_tick_conditioner.sv
// Push-button conditioner: 2-FF sync, debounce, press pulses with inc/dec auto-repeat
// and interlock, plus the clearable 1 s tick prescaler.
module btn_tick_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TICK_DIV        = 100_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 20_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_raw,
    input  logic inc_raw,
    input  logic dec_raw,
    input  logic tick_clr,
    output logic start_btn,
    output logic inc_btn,
    output logic dec_btn,
    output logic tick_1s
);

    localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned RD_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam int unsigned RR_W = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam int unsigned RW   = (RD_W > RR_W) ? RD_W : RR_W;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REPEAT
    } rep_state_t;

    // Bit 0 start, bit 1 inc, bit 2 dec.
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] db;
    logic       start_q;
    logic       both;
    logic [1:0] rep_pulse;
    logic [PW-1:0] pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {dec_raw, inc_raw, start_raw};
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                lvl <= sync2[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign db[g] = lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            start_btn <= 1'b0;
        end else begin
            start_q   <= db[0];
            start_btn <= db[0] & ~start_q;
        end
    end

    // IDLE reacts to the held level, so a button left held after the interlock
    // releases is taken as a fresh press.
    assign both = db[1] & db[2];

    for (genvar g = 0; g < 2; g++) begin : g_rep
        rep_state_t    state;
        rep_state_t    state_nx;
        logic [RW-1:0] rc;
        logic [RW-1:0] rc_nx;
        logic          pulse;
        logic          pulse_nx;
        logic          lvl;

        assign lvl = db[g+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_IDLE;
                rc    <= '0;
                pulse <= 1'b0;
            end else begin
                state <= state_nx;
                rc    <= rc_nx;
                pulse <= pulse_nx;
            end
        end

        always_comb begin
            state_nx = state;
            rc_nx    = rc;
            pulse_nx = 1'b0;
            if (both) begin
                state_nx = ST_IDLE;
                rc_nx    = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (lvl) begin
                            pulse_nx = 1'b1;
                            state_nx = ST_WAIT;
                            rc_nx    = '0;
                        end
                    end
                    ST_WAIT: begin
                        if (!lvl) begin
                            state_nx = ST_IDLE;
                            rc_nx    = '0;
                        end else if (rc == RD_LAST) begin
                            pulse_nx = 1'b1;
                            state_nx = ST_REPEAT;
                            rc_nx    = '0;
                        end else begin
                            rc_nx = rc + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!lvl) begin
                            state_nx = ST_IDLE;
                            rc_nx    = '0;
                        end else if (rc == RR_LAST) begin
                            pulse_nx = 1'b1;
                            rc_nx    = '0;
                        end else begin
                            rc_nx = rc + 1'b1;
                        end
                    end
                    default: begin
                        state_nx = ST_IDLE;
                        rc_nx    = '0;
                    end
                endcase
            end
        end

        assign rep_pulse[g] = pulse;
    end

    assign inc_btn = rep_pulse[0];
    assign dec_btn = rep_pulse[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            tick_1s <= 1'b0;
        end else if (tick_clr) begin
            pc      <= '0;
            tick_1s <= 1'b0;
        end else if (pc == PC_LAST) begin
            pc      <= '0;
            tick_1s <= 1'b1;
        end else begin
            pc      <= pc + 1'b1;
            tick_1s <= 1'b0;
        end
    end

endmodule
